dac_pulse_scheduler: RTL and testbench



---
 rtl/dac_pulse_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_dac_pulse_scheduler.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_pulse_scheduler.sv
// dac_pulse_scheduler: walks a register table of DAC pulses, replaying it
// repeat_cnt+1 times (or continuously while loop=1 when built with the
// optional loop feature).
//
// Ports:
//   clk, rstn                 clock, async active-low reset (also clears table)
//   wr_en/wr_addr/wr_current/
//   wr_width/wr_period        table write port, accepted in any state
//   num_entries, repeat_cnt   entries per pass / extra passes, latched at start
//   start, abort              begin sequence / stop immediately
//   loop                      only with DAC_PULSE_SCHED_LOOP_EN defined
//   busy, done                sequence in progress / one-cycle completion
//   entry_idx, trigger,
//   current, width            presented entry and its one-cycle trigger
//
// Optional feature macro: DAC_PULSE_SCHED_LOOP_EN

module dac_pulse_scheduler #(
    parameter int DEPTH    = 8,
    parameter int AW       = 3,
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [15:0]         wr_current,
    input  logic [15:0]         wr_width,
    input  logic [PERIOD_W-1:0] wr_period,
    input  logic [AW:0]         num_entries,
    input  logic [15:0]         repeat_cnt,
    input  logic                start,
    input  logic                abort,
`ifdef DAC_PULSE_SCHED_LOOP_EN
    input  logic                loop,
`endif
    output logic                busy,
    output logic                done,
    output logic [AW-1:0]       entry_idx,
    output logic                trigger,
    output logic [15:0]         current,
    output logic [15:0]         width
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TRIG,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);

    logic [15:0]         tab_cur [DEPTH];
    logic [15:0]         tab_wid [DEPTH];
    logic [PERIOD_W-1:0] tab_per [DEPTH];

    state_t              state;
    logic [AW-1:0]       idx;
    logic [AW:0]         last;
    logic [15:0]         rep;
    logic [PERIOD_W-1:0] cnt;
    logic                empty_q;

    logic [AW:0]         n_cl;
    logic [PERIOD_W-1:0] per_sel;
    logic [PERIOD_W-1:0] hold_val;
    logic                loop_hit;

    assign n_cl    = (num_entries > DEPTH_N) ? DEPTH_N : num_entries;
    assign per_sel = tab_per[idx];

    // TRIG plus the HOLD cycles plus the next LOAD add up to one period;
    // periods below 4 are stretched to the 4-cycle minimum.
    assign hold_val = (per_sel < PERIOD_W'(4)) ? PERIOD_W'(2)
                                               : per_sel - PERIOD_W'(2);

`ifdef DAC_PULSE_SCHED_LOOP_EN
    assign loop_hit = loop;
`else
    assign loop_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                tab_cur[i] <= '0;
                tab_wid[i] <= '0;
                tab_per[i] <= '0;
            end
        end else if (wr_en) begin
            tab_cur[wr_addr] <= wr_current;
            tab_wid[wr_addr] <= wr_width;
            tab_per[wr_addr] <= wr_period;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            idx       <= '0;
            last      <= '0;
            rep       <= '0;
            cnt       <= '0;
            empty_q   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            trigger   <= 1'b0;
            entry_idx <= '0;
            current   <= '0;
            width     <= '0;
        end else begin
            trigger <= 1'b0;
            done    <= 1'b0;
            if (abort) begin
                state   <= S_IDLE;
                busy    <= 1'b0;
                empty_q <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start) begin
                            if (n_cl == '0) begin
                                // Empty table: spend one extra cycle so
                                // done lands two cycles after start.
                                state   <= S_DONE;
                                empty_q <= 1'b1;
                            end else begin
                                state <= S_LOAD;
                                busy  <= 1'b1;
                                idx   <= '0;
                                rep   <= repeat_cnt;
                                last  <= n_cl - (AW+1)'(1);
                            end
                        end
                    end
                    S_LOAD: begin
                        current   <= tab_cur[idx];
                        width     <= tab_wid[idx];
                        entry_idx <= idx;
                        cnt       <= hold_val;
                        trigger   <= 1'b1;
                        state     <= S_TRIG;
                    end
                    S_TRIG: begin
                        state <= S_HOLD;
                    end
                    S_HOLD: begin
                        if (cnt == PERIOD_W'(1)) begin
                            if ({1'b0, idx} != last) begin
                                idx   <= idx + 1'b1;
                                state <= S_LOAD;
                            end else if (loop_hit) begin
                                idx   <= '0;
                                state <= S_LOAD;
                            end else if (rep != '0) begin
                                rep   <= rep - 1'b1;
                                idx   <= '0;
                                state <= S_LOAD;
                            end else begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    S_DONE: begin
                        if (empty_q) begin
                            empty_q <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dac_pulse_scheduler.sv
// tb_dac_pulse_scheduler: directed stimulus with a cycle-schedule model
// compared every cycle, plus hand-computed literal expectations.

module tb_dac_pulse_scheduler;

    logic        clk = 1'b0;
    logic        rstn;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_current;
    logic [15:0] wr_width;
    logic [23:0] wr_period;
    logic [3:0]  num_entries;
    logic [15:0] repeat_cnt;
    logic        start;
    logic        abort;
    logic        loop;
    logic        busy;
    logic        done;
    logic [2:0]  entry_idx;
    logic        trigger;
    logic [15:0] current;
    logic [15:0] width;

    dac_pulse_scheduler dut (
        .clk         (clk),
        .rstn        (rstn),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_current  (wr_current),
        .wr_width    (wr_width),
        .wr_period   (wr_period),
        .num_entries (num_entries),
        .repeat_cnt  (repeat_cnt),
        .start       (start),
        .abort       (abort),
`ifdef DAC_PULSE_SCHED_LOOP_EN
        .loop        (loop),
`endif
        .busy        (busy),
        .done        (done),
        .entry_idx   (entry_idx),
        .trigger     (trigger),
        .current     (current),
        .width       (width)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     nm, cyc, act, exp);
        end
    endtask

    // Trigger / done monitor used by the literal checks.
    int          tq_c[$];
    int          tq_i[$];
    logic [15:0] tq_v[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (trigger) begin
            tq_c.push_back(cyc);
            tq_i.push_back(int'(entry_idx));
            tq_v.push_back(current);
        end
        if (done) done_cnt++;
    end

    // Schedule model: tracks when the next trigger is due and which
    // entry it presents, from the start cycle and the periods.
    int          rst_req = 0;
    int          rst_seen = 0;
    logic [15:0] m_cur [8];
    logic [15:0] m_wid [8];
    int          m_per [8];
    bit          act = 0;
    bit          emp = 0;
    int          nxt = -1;
    int          dcyc = -1;
    int          didx = 0;
    int          rep_left = 0;
    int          nn = 0;
    logic [15:0] s_cur = '0;
    logic [15:0] s_wid = '0;
    int          s_per = 0;
    logic [15:0] e_cur = '0;
    logic [15:0] e_wid = '0;
    int          e_idx = 0;

    initial begin
        for (int i = 0; i < 8; i++) begin
            m_cur[i] = '0;
            m_wid[i] = '0;
            m_per[i] = 0;
        end
    end

    always @(negedge clk) begin
        bit et;
        bit ed;
        bit eb;
        int p;
        if (rst_req != rst_seen) begin
            rst_seen = rst_req;
            act = 0;
            e_cur = '0;
            e_wid = '0;
            e_idx = 0;
            for (int i = 0; i < 8; i++) begin
                m_cur[i] = '0;
                m_wid[i] = '0;
                m_per[i] = 0;
            end
        end
        et = act && !emp && (cyc == nxt);
        ed = act && (cyc == dcyc);
        eb = act && !emp && (dcyc < 0 || cyc < dcyc);
        if (et) begin
            e_cur = s_cur;
            e_wid = s_wid;
            e_idx = didx;
        end
        chk("trigger", 32'(trigger), 32'(et));
        chk("done", 32'(done), 32'(ed));
        chk("busy", 32'(busy), 32'(eb));
        chk("current", 32'(current), 32'(e_cur));
        chk("width", 32'(width), 32'(e_wid));
        chk("entry_idx", 32'(entry_idx), 32'(e_idx));
        if (et) begin
            p = (s_per < 4) ? 4 : s_per;
            if (didx < nn - 1) begin
                didx++;
                nxt = cyc + p;
            end else if (loop || rep_left > 0) begin
                if (!loop) rep_left--;
                didx = 0;
                nxt = cyc + p;
            end else begin
                dcyc = cyc + p - 1;
                nxt = -1;
            end
        end
        if (rstn) begin
            if (wr_en) begin
                m_cur[wr_addr] = wr_current;
                m_wid[wr_addr] = wr_width;
                m_per[wr_addr] = int'(wr_period);
            end
            if (abort) begin
                act = 0;
            end else if (start && !act) begin
                nn = (num_entries > 8) ? 8 : int'(num_entries);
                act = 1;
                if (nn == 0) begin
                    emp = 1;
                    dcyc = cyc + 2;
                    nxt = -1;
                end else begin
                    emp = 0;
                    dcyc = -1;
                    didx = 0;
                    rep_left = int'(repeat_cnt);
                    nxt = cyc + 2;
                end
            end
            if (act && !emp && dcyc < 0 && cyc == nxt - 2) begin
                s_cur = m_cur[didx];
                s_wid = m_wid[didx];
                s_per = m_per[didx];
            end
        end
        if (act && cyc == dcyc) act = 0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        int g = 0;
        while (cyc < c && g < 1000) begin
            step();
            g++;
        end
    endtask

    task automatic wr(input int a, input logic [15:0] c,
                      input logic [15:0] w, input int p);
        step();
        wr_en = 1'b1;
        wr_addr = 3'(a);
        wr_current = c;
        wr_width = w;
        wr_period = 24'(p);
        step();
        wr_en = 1'b0;
    endtask

    task automatic clear_q();
        tq_c.delete();
        tq_i.delete();
        tq_v.delete();
    endtask

    task automatic go(output int s);
        step();
        start = 1'b1;
        s = cyc;
        step();
        start = 1'b0;
    endtask

    initial begin
        int s;
        int d0;
        int exp_gap[5];
        exp_gap = '{8, 5, 4, 8, 5};
        rstn = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_current = '0;
        wr_width = '0;
        wr_period = '0;
        num_entries = '0;
        repeat_cnt = '0;
        start = 1'b0;
        abort = 1'b0;
        loop = 1'b0;
        repeat (3) step();
        rstn = 1'b1;
        step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_trigger", 32'(trigger), 0);
        chk("rst_current", 32'(current), 0);
        chk("rst_width", 32'(width), 0);
        chk("rst_entry_idx", 32'(entry_idx), 0);

        // Single pass
        wr(0, 16'h1234, 16'd10, 20);
        num_entries = 4'd1;
        repeat_cnt = 16'd0;
        clear_q();
        d0 = done_cnt;
        go(s);
        goto(s + 1);
        chk("t1_busy_k1", 32'(busy), 1);
        goto(s + 2);
        chk("t1_trig_k2", 32'(trigger), 1);
        chk("t1_current", 32'(current), 32'h1234);
        chk("t1_width", 32'(width), 10);
        goto(s + 21);
        chk("t1_done_at_19", 32'(done), 1);
        goto(s + 30);
        chk("t1_done_once", 32'(done_cnt - d0), 1);
        chk("t1_trig_count", 32'(tq_c.size()), 1);

        // Three entries, periods 8/5/3, one repeat
        wr(0, 16'h0100, 16'd1, 8);
        wr(1, 16'h0200, 16'd2, 5);
        wr(2, 16'h0300, 16'd3, 3);
        num_entries = 4'd3;
        repeat_cnt = 16'd1;
        clear_q();
        go(s);
        goto(s + 45);
        chk("t2_trig_count", 32'(tq_c.size()), 6);
        if (tq_c.size() > 0) chk("t2_first", 32'(tq_c[0] - s), 2);
        for (int i = 0; i < 5; i++)
            if (i + 1 < tq_c.size())
                chk("t2_gap", 32'(tq_c[i+1] - tq_c[i]), 32'(exp_gap[i]));
        for (int i = 0; i < 6; i++)
            if (i < tq_i.size())
                chk("t2_idx", 32'(tq_i[i]), 32'(i % 3));

        // Empty table
        num_entries = 4'd0;
        repeat_cnt = 16'd0;
        clear_q();
        go(s);
        goto(s + 1);
        chk("t3_done_k1", 32'(done), 0);
        chk("t3_busy_k1", 32'(busy), 0);
        goto(s + 2);
        chk("t3_done_k2", 32'(done), 1);
        chk("t3_busy_k2", 32'(busy), 0);
        goto(s + 6);
        chk("t3_no_trig", 32'(tq_c.size()), 0);

        // Abort during HOLD of entry1
        num_entries = 4'd3;
        clear_q();
        d0 = done_cnt;
        go(s);
        goto(s + 12);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4_busy_off", 32'(busy), 0);
        chk("t4_current_kept", 32'(current), 32'h0200);
        chk("t4_idx_kept", 32'(entry_idx), 1);
        goto(s + 40);
        chk("t4_trig_count", 32'(tq_c.size()), 2);
        chk("t4_no_done", 32'(done_cnt - d0), 0);

        // Start and abort together
        clear_q();
        step();
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        s = cyc;
        goto(s + 2);
        chk("t4b_busy", 32'(busy), 0);
        goto(s + 10);
        chk("t4b_no_trig", 32'(tq_c.size()), 0);

        // Rewrite entry2 mid-run, start while busy
        wr(0, 16'h0AAA, 16'd4, 20);
        repeat_cnt = 16'd0;
        clear_q();
        d0 = done_cnt;
        go(s);
        goto(s + 5);
        wr_en = 1'b1;
        wr_addr = 3'd2;
        wr_current = 16'hBEEF;
        wr_width = 16'd77;
        wr_period = 24'd6;
        step();
        wr_en = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        goto(s + 45);
        chk("t5_trig_count", 32'(tq_c.size()), 3);
        if (tq_v.size() > 2) chk("t5_new_entry2", 32'(tq_v[2]), 32'hBEEF);
        chk("t5_done_once", 32'(done_cnt - d0), 1);

        // Reset in HOLD, then clamp of num_entries
        go(s);
        goto(s + 6);
        #1;
        rstn = 1'b0;
        rst_req++;
        #1;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_trigger", 32'(trigger), 0);
        chk("t6_done", 32'(done), 0);
        chk("t6_current", 32'(current), 0);
        chk("t6_width", 32'(width), 0);
        chk("t6_entry_idx", 32'(entry_idx), 0);
        step();
        step();
        rstn = 1'b1;
        num_entries = 4'd9;
        clear_q();
        d0 = done_cnt;
        go(s);
        goto(s + 2);
        chk("t7_trig", 32'(trigger), 1);
        chk("t7_current_cleared", 32'(current), 0);
        goto(s + 33);
        chk("t7_done", 32'(done), 1);
        goto(s + 40);
        chk("t7_trig_count", 32'(tq_c.size()), 8);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
